// File: rtl/ram64_ctrl_pkg.sv
// ram64_ctrl_pkg: shared sizes and state encoding for the ram64 front end
package ram64_ctrl_pkg;
    localparam int RAM64_WORDS = 64;
    localparam int RAM64_AW = 6;
    localparam int WORD_W = 16;
    typedef enum logic {CLEAR, RUN} state_t;
endpackage

// File: rtl/ram64_ctrl.sv
// ram64_ctrl: serialises valid/ready requests into ram64 accesses with registered responses
module ram64_ctrl
    import ram64_ctrl_pkg::*;
#(
    parameter logic [WORD_W-1:0] FILL_VALUE = 16'h0000,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clr_start,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [RAM64_AW-1:0] req_addr,
    input  logic [WORD_W-1:0]   req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_we,
    output logic [WORD_W-1:0]   rsp_data,
    output logic                busy,
    output logic [WORD_W-1:0]   mem_in,
    output logic [RAM64_AW-1:0] mem_address,
    output logic                mem_load,
    input  logic [WORD_W-1:0]   mem_out
);
    state_t state_q, state_d;
    logic [RAM64_AW-1:0] clr_addr_q, clr_addr_d;
    logic rsp_valid_q, rsp_valid_d, rsp_we_q, rsp_we_d, accept;
    logic [WORD_W-1:0] rsp_data_q, rsp_data_d;

    always_comb begin
        state_d = state_q;
        clr_addr_d = clr_addr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_we_d = rsp_we_q;
        rsp_data_d = rsp_data_q;
        busy = state_q == CLEAR;
        req_ready = state_q == RUN && !clr_start && (!rsp_valid_q || rsp_ready);
        accept = req_valid && req_ready;
        mem_load = busy || (accept && req_we);
        mem_address = busy ? clr_addr_q : req_addr;
        mem_in = busy ? FILL_VALUE : req_wdata;
        if (busy) begin
            clr_addr_d = clr_addr_q + 1'b1;
            state_d = clr_addr_q == RAM64_AW'(RAM64_WORDS - 1) ? RUN : CLEAR;
        end else if (clr_start) begin
            state_d = CLEAR;
            clr_addr_d = '0;
        end
        // a new accept overwrites the response slot; otherwise a consumed response retires
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_we_d = req_we;
            rsp_data_d = req_we ? req_wdata : mem_out;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= CLEAR_ON_RESET ? CLEAR : RUN;
            clr_addr_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_we_q <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            state_q <= state_d;
            clr_addr_q <= clr_addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_we_q <= rsp_we_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_we = rsp_we_q;
    assign rsp_data = rsp_data_q;
endmodule

// File: tb/tb_ram64_ctrl.sv
// tb_ram64_ctrl: directed scoreboard bench for ram64_ctrl with a behavioural ram64 alongside
module tb_ram64_ctrl;
    import ram64_ctrl_pkg::*;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n, clr_start, req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_we, busy, mem_load;
    logic [5:0] req_addr, mem_address;
    logic [15:0] req_wdata, rsp_data, mem_in, mem_out;
    typedef struct packed {logic we; logic [15:0] data;} rsp_t;
    rsp_t sb[$];
    logic [15:0] mdl[64];
    logic [15:0] ram[64];
    int checks = 0, errors = 0, pops = 0;
    bit prev_acc = 1'b0;

    ram64_ctrl dut (
        .clk(clk), .reset_n(reset_n), .clr_start(clr_start), .req_valid(req_valid),
        .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we), .rsp_data(rsp_data),
        .busy(busy), .mem_in(mem_in), .mem_address(mem_address), .mem_load(mem_load),
        .mem_out(mem_out)
    );

    always @(posedge clk) if (mem_load) ram[mem_address] <= mem_in;
    assign mem_out = ram[mem_address];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic go();
        rsp_t e;
        settle();
        if (prev_acc) chk("latency", 32'(rsp_valid), 1);
        prev_acc = 1'b0;
        if (reset_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) chk("sb_underflow", sb.size(), 1);
            else begin
                e = sb.pop_front();
                chk("rsp_we", 32'(rsp_we), 32'(e.we));
                chk("rsp_data", 32'(rsp_data), 32'(e.data));
                pops++;
            end
        end
        if (reset_n && req_valid && req_ready) begin
            sb.push_back({req_we, req_we ? req_wdata : mdl[req_addr]});
            if (req_we) mdl[req_addr] = req_wdata;
            prev_acc = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input logic v, input logic we, input logic [5:0] a, input logic [15:0] d);
        req_valid = v;
        req_we = we;
        req_addr = a;
        req_wdata = d;
    endtask

    task automatic clear_walk();
        int n = 0;
        settle();
        while (busy === 1'b1 && n < 80) begin
            chk("clr_addr", 32'(mem_address), n);
            chk("clr_load", 32'(mem_load), 1);
            chk("clr_ready", 32'(req_ready), 0);
            go();
            settle();
            n++;
        end
        chk("clr_len", n, 64);
    endtask

    initial begin
        int base, n;
        for (int i = 0; i < 64; i++) begin
            ram[i] = 16'($urandom);
            mdl[i] = 16'h0000;
        end
        reset_n = 1'b0;
        clr_start = 1'b0;
        rsp_ready = 1'b1;
        set_req(1'b0, 1'b0, 6'd0, 16'h0);
        @(negedge clk);
        go();
        go();
        reset_n = 1'b1;
        settle();
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_busy", 32'(busy), 1);
        clear_walk();
        set_req(1'b1, 1'b0, 6'd63, 16'h0);
        go();
        set_req(1'b0, 1'b0, 6'd0, 16'h0);
        go();
        // write then immediate read-back of the same word
        set_req(1'b1, 1'b1, 6'd9, 16'h1234);
        go();
        set_req(1'b1, 1'b0, 6'd9, 16'h0);
        go();
        set_req(1'b0, 1'b0, 6'd0, 16'h0);
        go();
        base = pops;
        for (int k = 0; k < 8; k++) begin
            set_req(1'b1, 1'b1, 6'(k), 16'(k * 16'h0101));
            go();
        end
        for (int k = 0; k < 8; k++) begin
            set_req(1'b1, 1'b0, 6'(k), 16'h0);
            go();
        end
        set_req(1'b0, 1'b0, 6'd0, 16'h0);
        go();
        chk("burst_rsp_count", pops - base, 16);
        set_req(1'b1, 1'b0, 6'd9, 16'h0);
        rsp_ready = 1'b0;
        go();
        set_req(1'b1, 1'b0, 6'd1, 16'h0);
        for (int i = 0; i < 3; i++) begin
            go();
            settle();
            chk("bp_req_ready", 32'(req_ready), 0);
            chk("bp_mem_load", 32'(mem_load), 0);
            chk("bp_rsp_valid", 32'(rsp_valid), 1);
            chk("bp_rsp_data", 32'(rsp_data), 32'h1234);
        end
        rsp_ready = 1'b1;
        settle();
        chk("bp_release_ready", 32'(req_ready), 1);
        go();
        set_req(1'b1, 1'b1, 6'd20, 16'habcd);
        go();
        set_req(1'b1, 1'b1, 6'd21, 16'h5555);
        clr_start = 1'b1;
        settle();
        chk("clr_prio_ready", 32'(req_ready), 0);
        go();
        clr_start = 1'b0;
        for (int i = 0; i < 64; i++) mdl[i] = 16'h0000;
        clear_walk();
        chk("post_clr_ready", 32'(req_ready), 1);
        go();
        set_req(1'b1, 1'b0, 6'd20, 16'h0);
        go();
        set_req(1'b1, 1'b0, 6'd21, 16'h0);
        go();
        set_req(1'b1, 1'b0, 6'd5, 16'h0);
        go();
        set_req(1'b1, 1'b0, 6'd9, 16'h0);
        rsp_ready = 1'b0;
        go();
        set_req(1'b0, 1'b0, 6'd0, 16'h0);
        clr_start = 1'b1;
        go();
        clr_start = 1'b0;
        settle();
        n = 0;
        while (mem_address !== 6'd30 && n < 40) begin
            go();
            settle();
            n++;
        end
        chk("mid_clr_addr", 32'(mem_address), 30);
        chk("held_rsp_in_clr", 32'(rsp_valid), 1);
        reset_n = 1'b0;
        go();
        reset_n = 1'b1;
        sb.delete();
        prev_acc = 1'b0;
        settle();
        chk("rst2_rsp_valid", 32'(rsp_valid), 0);
        clear_walk();
        rsp_ready = 1'b1;
        set_req(1'b1, 1'b0, 6'd9, 16'h0);
        go();
        set_req(1'b0, 1'b0, 6'd0, 16'h0);
        go();
        go();
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
